// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the decode-stage hazard/flush controller.
package pipe_ctrl_pkg;

  localparam int unsigned REG_ADDR_W  = 5;
  localparam int unsigned FLUSH_CNT_W = 4;

  typedef enum logic [0:0] {
    RUN,
    FLUSH
  } pipe_ctrl_state_e;

endpackage

// File: rtl/pipe_scoreboard.sv
// Register scoreboard for long-latency results, with same-cycle writeback bypass.
module pipe_scoreboard
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_addr,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_addr,
  output logic [NUM_REGS-1:0]   pending,
  output logic [NUM_REGS-1:0]   eff
);

  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [NUM_REGS-1:0] set_mask, clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en && (set_addr != '0)) set_mask[set_addr] = 1'b1;
    if (clr_en) clr_mask[clr_addr] = 1'b1;
    // Register file is write-through, so a same-cycle writeback already resolves the hazard.
    eff       = pending_q & ~clr_mask;
    pending_d = (pending_q & ~clr_mask) | set_mask;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  assign pending = pending_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Decode-stage stall/flush controller: scoreboard, divider occupancy and mispredict flush FSM.
// Optional saturating perf counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REGS     = 32,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dec_valid,
  input  logic                  dec_rs1,
  input  logic [REG_ADDR_W-1:0] dec_rs1_addr,
  input  logic                  dec_rs2,
  input  logic [REG_ADDR_W-1:0] dec_rs2_addr,
  input  logic                  dec_rd,
  input  logic [REG_ADDR_W-1:0] dec_rd_addr,
  input  logic                  dec_long,
  input  logic                  dec_div,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd_addr,
  input  logic                  div_done,
  input  logic                  mispredict,
  output logic                  pipe_stall,
  output logic                  pipe_flush,
  output logic                  issue,
  output logic [NUM_REGS-1:0]   sb_pending
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_events
`endif
);

  localparam logic [FLUSH_CNT_W-1:0] FlushLoad = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  pipe_ctrl_state_e       state_q, state_d;
  logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;
  logic                   div_busy_q, div_busy_d;
  logic [NUM_REGS-1:0]    eff;
  logic                   raw, waw, div_struct, sb_set;

  pipe_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (sb_set),
    .set_addr (dec_rd_addr),
    .clr_en   (wb_valid),
    .clr_addr (wb_rd_addr),
    .pending  (sb_pending),
    .eff      (eff)
  );

  always_comb begin
    raw        = (dec_rs1 & eff[dec_rs1_addr]) | (dec_rs2 & eff[dec_rs2_addr]);
    waw        = dec_rd & eff[dec_rd_addr];
    div_struct = dec_div & div_busy_q & ~div_done;
    pipe_stall = dec_valid & (raw | waw | div_struct) & (state_q == RUN);
    issue      = dec_valid & ~pipe_stall & ~pipe_flush;
    sb_set     = issue & dec_long & dec_rd;
    // A new divide issuing in the completion cycle keeps the unit busy.
    div_busy_d = (issue & dec_div) | (div_busy_q & ~div_done);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (mispredict) begin
          state_d = FLUSH;
          cnt_d   = FlushLoad;
        end
      end
      FLUSH: begin
        if (mispredict)          cnt_d   = FlushLoad;
        else if (cnt_q == '0)    state_d = RUN;
        else                     cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      div_busy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_busy_q <= div_busy_d;
    end
  end

  assign pipe_flush = (state_q == FLUSH);

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_events_q, flush_events_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if (pipe_stall && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + 1'b1;
    if (mispredict && (flush_events_q != '1)) flush_events_d = flush_events_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized traffic vs a behavioural model.
module tb_pipe_ctrl;

  localparam int NR = 32;
  localparam int FC = 2;
  localparam int CW = 32;
  localparam longint CntMax = 64'h0000_0000_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst;
  logic dec_valid, dec_rs1, dec_rs2, dec_rd, dec_long, dec_div;
  logic [4:0] dec_rs1_addr, dec_rs2_addr, dec_rd_addr, wb_rd_addr;
  logic wb_valid, div_done, mispredict;
  logic pipe_stall, pipe_flush, issue;
  logic [NR-1:0] sb_pending;
`ifdef PIPE_CTRL_PERF_EN
  logic [CW-1:0] stall_cycles, flush_events;
`endif

  pipe_ctrl #(
    .NUM_REGS     (NR),
    .FLUSH_CYCLES (FC),
    .CNT_W        (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .dec_valid    (dec_valid),
    .dec_rs1      (dec_rs1),
    .dec_rs1_addr (dec_rs1_addr),
    .dec_rs2      (dec_rs2),
    .dec_rs2_addr (dec_rs2_addr),
    .dec_rd       (dec_rd),
    .dec_rd_addr  (dec_rd_addr),
    .dec_long     (dec_long),
    .dec_div      (dec_div),
    .wb_valid     (wb_valid),
    .wb_rd_addr   (wb_rd_addr),
    .div_done     (div_done),
    .mispredict   (mispredict),
    .pipe_stall   (pipe_stall),
    .pipe_flush   (pipe_flush),
    .issue        (issue),
    .sb_pending   (sb_pending)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural model state
  bit     pend [NR];
  bit     busy;
  int     flush_left;
  longint m_stall, m_flush;
  logic   exp_stall, exp_issue, exp_flush;
  logic [NR-1:0] exp_pend;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NR; i++) pend[i] = 1'b0;
    busy = 1'b0;
    flush_left = 0;
    m_stall = 0;
    m_flush = 0;
  endfunction

  function automatic void model_eval();
    bit eff [NR];
    bit hazard;
    for (int i = 0; i < NR; i++) begin
      eff[i] = pend[i] && !(wb_valid && (int'(wb_rd_addr) == i));
      exp_pend[i] = pend[i];
    end
    exp_flush = (flush_left > 0);
    hazard = (dec_rs1 && eff[dec_rs1_addr]) || (dec_rs2 && eff[dec_rs2_addr]) ||
             (dec_rd && eff[dec_rd_addr]) || (dec_div && busy && !div_done);
    exp_stall = dec_valid && hazard && !exp_flush;
    exp_issue = dec_valid && !exp_stall && !exp_flush;
  endfunction

  function automatic void model_update();
    bit set_hit;
    set_hit = exp_issue && dec_long && dec_rd && (dec_rd_addr != 5'd0);
    for (int i = 0; i < NR; i++)
      pend[i] = (set_hit && (int'(dec_rd_addr) == i)) ||
                (pend[i] && !(wb_valid && (int'(wb_rd_addr) == i)));
    busy = (exp_issue && dec_div) || (busy && !div_done);
    if (mispredict) flush_left = FC;
    else if (flush_left > 0) flush_left--;
    if (exp_stall && m_stall < CntMax) m_stall++;
    if (mispredict && m_flush < CntMax) m_flush++;
  endfunction

  // Inputs are set at the negedge; compare, then advance one full cycle.
  task automatic step();
    #1;
    model_eval();
    chk("pipe_stall", 64'(pipe_stall), 64'(exp_stall));
    chk("issue", 64'(issue), 64'(exp_issue));
    chk("pipe_flush", 64'(pipe_flush), 64'(exp_flush));
    chk("sb_pending", 64'(sb_pending), 64'(exp_pend));
`ifdef PIPE_CTRL_PERF_EN
    chk("stall_cycles", 64'(stall_cycles), 64'(m_stall));
    chk("flush_events", 64'(flush_events), 64'(m_flush));
`endif
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0; dec_long = 0; dec_div = 0;
    dec_rs1_addr = 0; dec_rs2_addr = 0; dec_rd_addr = 0;
    wb_valid = 0; wb_rd_addr = 0; div_done = 0; mispredict = 0;
  endtask

  task automatic set_dec(input logic rs1, input logic [4:0] a1, input logic rs2,
                         input logic [4:0] a2, input logic rd, input logic [4:0] ad,
                         input logic lng, input logic dv);
    dec_valid = 1; dec_rs1 = rs1; dec_rs1_addr = a1; dec_rs2 = rs2; dec_rs2_addr = a2;
    dec_rd = rd; dec_rd_addr = ad; dec_long = lng; dec_div = dv;
  endtask

  initial begin
    idle();
    model_reset();
    rst = 1'b1;
    #2;
    chk("rst_stall", 64'(pipe_stall), 64'd0);
    chk("rst_flush", 64'(pipe_flush), 64'd0);
    chk("rst_pending", 64'(sb_pending), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Load to x5, then add x6,x5,x1 waits for the x5 writeback.
    set_dec(0, 0, 0, 0, 1, 5'd5, 1, 0);
    #1 chk("load_issue", 64'(issue), 64'd1);
    step();
    set_dec(1, 5'd5, 1, 5'd1, 1, 5'd6, 0, 0);
    #1 chk("raw_stall0", 64'(pipe_stall), 64'd1);
    step();
    #1 chk("raw_stall1", 64'(pipe_stall), 64'd1);
    step();
    wb_valid = 1; wb_rd_addr = 5'd5;
    #1 chk("raw_wb_stall", 64'(pipe_stall), 64'd0);
    chk("raw_wb_issue", 64'(issue), 64'd1);
    step();
    idle();

    // Long op to x0 never marks pending; x0 readers do not stall.
    set_dec(0, 0, 0, 0, 1, 5'd0, 1, 0);
    step();
    set_dec(1, 5'd0, 1, 5'd0, 1, 5'd0, 0, 0);
    #1 chk("x0_pending", 64'(sb_pending), 64'd0);
    chk("x0_stall", 64'(pipe_stall), 64'd0);
    step();
    idle();

    // Divider structural hazard.
    set_dec(0, 0, 0, 0, 0, 0, 1, 1);
    #1 chk("div1_issue", 64'(issue), 64'd1);
    step();
    #1 chk("div2_stall0", 64'(pipe_stall), 64'd1);
    step();
    #1 chk("div2_stall1", 64'(pipe_stall), 64'd1);
    step();
    div_done = 1;
    #1 chk("div2_done_stall", 64'(pipe_stall), 64'd0);
    chk("div2_done_issue", 64'(issue), 64'd1);
    step();
    div_done = 0;
    #1 chk("div3_busy_stall", 64'(pipe_stall), 64'd1);
    step();
    idle();
    div_done = 1;
    step();
    idle();

    // Same-cycle set and clear of x7: set wins.
    set_dec(0, 0, 0, 0, 1, 5'd7, 1, 0);
    wb_valid = 1; wb_rd_addr = 5'd7;
    step();
    idle();
    #1 chk("x7_set_wins", 64'(sb_pending[7]), 64'd1);
    step();

    // Mispredict at N with a dependent instruction waiting on x7.
    mispredict = 1;
    step();
    mispredict = 0;
    set_dec(1, 5'd7, 0, 0, 0, 0, 0, 0);
    #1 chk("fl_n1_flush", 64'(pipe_flush), 64'd1);
    chk("fl_n1_stall", 64'(pipe_stall), 64'd0);
    chk("fl_n1_issue", 64'(issue), 64'd0);
    step();
    #1 chk("fl_n2_flush", 64'(pipe_flush), 64'd1);
    chk("fl_n2_stall", 64'(pipe_stall), 64'd0);
    step();
    #1 chk("fl_n3_flush", 64'(pipe_flush), 64'd0);
    chk("fl_n3_stall", 64'(pipe_stall), 64'd1);
    step();
    idle();

    // Repeated mispredict extends the flush.
    mispredict = 1;
    step();
    #1 chk("rep_n1_flush", 64'(pipe_flush), 64'd1);
    step();
    mispredict = 0;
    #1 chk("rep_n2_flush", 64'(pipe_flush), 64'd1);
    step();
    #1 chk("rep_n3_flush", 64'(pipe_flush), 64'd1);
    step();
    #1 chk("rep_n4_flush", 64'(pipe_flush), 64'd0);
    step();

    // Asynchronous reset in the middle of a flush.
    mispredict = 1;
    step();
    mispredict = 0;
    #1 chk("mid_flush_on", 64'(pipe_flush), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("arst_flush", 64'(pipe_flush), 64'd0);
    chk("arst_stall", 64'(pipe_stall), 64'd0);
    chk("arst_issue", 64'(issue), 64'd0);
    chk("arst_pending", 64'(sb_pending), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Three stall cycles on x9.
    set_dec(0, 0, 0, 0, 1, 5'd9, 1, 0);
    step();
    set_dec(1, 5'd9, 0, 0, 0, 0, 0, 0);
    repeat (3) step();
    idle();
    wb_valid = 1; wb_rd_addr = 5'd9;
`ifdef PIPE_CTRL_PERF_EN
    #1 chk("perf_stall3", 64'(stall_cycles), 64'd3);
`endif
    step();
    idle();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      dec_valid    = ($urandom_range(0, 9) < 7);
      dec_rs1      = $urandom_range(0, 1);
      dec_rs2      = $urandom_range(0, 1);
      dec_rd       = $urandom_range(0, 1);
      dec_rs1_addr = 5'($urandom_range(0, 7));
      dec_rs2_addr = 5'($urandom_range(0, 7));
      dec_rd_addr  = 5'($urandom_range(0, 7));
      dec_long     = ($urandom_range(0, 9) < 4);
      dec_div      = dec_long && ($urandom_range(0, 9) < 3);
      wb_valid     = ($urandom_range(0, 99) < 35);
      wb_rd_addr   = 5'($urandom_range(0, 7));
      div_done     = ($urandom_range(0, 9) < 2);
      mispredict   = ($urandom_range(0, 99) < 3);
      step();
    end
    idle();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
